// File: rtl/alarm_ringer.sv
// Alarm ringer: beeps a gated tone and LED while `ring` is high, debounces the stop button, returns a one-cycle cancel.
// Optional auto-cancel after TIMEOUT_BEEPS complete beeps when RINGER_TIMEOUT_EN is defined.
module alarm_ringer #(
    parameter int TONE_DIV      = 50_000,
    parameter int BEEP_ON       = 25_000_000,
    parameter int BEEP_OFF      = 25_000_000,
    parameter int DEBOUNCE      = 1_000_000,
    parameter int TIMEOUT_BEEPS = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ring,
    input  logic btn_stop,
    output logic cancel,
    output logic buzzer,
    output logic led,
    output logic ringing
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BEEP_ON  = 3'd1;
    localparam logic [2:0] ST_BEEP_OFF = 3'd2;
    localparam logic [2:0] ST_CANCEL   = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;

    localparam int PHASE_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W      = $clog2(PHASE_MAX + 1);
    localparam int TN_W      = $clog2(TONE_DIV + 1);
    localparam int DB_W      = $clog2(DEBOUNCE + 1);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF - 1);
    localparam logic [TN_W-1:0] TN_LAST  = TN_W'(TONE_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);

    logic            sync1_r, sync2_r;
    logic            deb_r, deb_d_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            press_s;
    logic [2:0]      state_r, state_nx_s;
    logic [PH_W-1:0] phase_r;
    logic [TN_W-1:0] tone_r;
    logic            phase_done_s;
    logic            timeout_hit_s;

    // Two-flop synchroniser for the asynchronous stop button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_stop;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r    <= 1'b0;
            deb_d_r  <= 1'b0;
            db_cnt_r <= '0;
        end else begin
            deb_d_r <= deb_r;
            if (sync2_r == deb_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                deb_r    <= sync2_r;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end
        end
    end

    assign press_s = deb_r & ~deb_d_r;

`ifdef RINGER_TIMEOUT_EN
    localparam int BP_W = $clog2(TIMEOUT_BEEPS + 1);
    localparam logic [BP_W-1:0] BEEP_LAST = BP_W'(TIMEOUT_BEEPS - 1);
    logic [BP_W-1:0] beep_r;

    // Completed-beep counter; the last beep's off-phase expiry triggers the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_r <= '0;
        end else if (state_r == ST_IDLE) begin
            beep_r <= '0;
        end else if (state_r == ST_BEEP_OFF && state_nx_s == ST_BEEP_ON) begin
            beep_r <= beep_r + 1'b1;
        end else begin
            beep_r <= beep_r;
        end
    end

    assign timeout_hit_s = (beep_r == BEEP_LAST);
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_BEEPS > 32'sd0);
    assign timeout_hit_s    = 1'b0;
`endif

    // Phase expiry for whichever beep half is active
    always_comb begin
        phase_done_s = 1'b0;
        if (state_r == ST_BEEP_ON) begin
            phase_done_s = (phase_r == ON_LAST);
        end else if (state_r == ST_BEEP_OFF) begin
            phase_done_s = (phase_r == OFF_LAST);
        end else begin
            phase_done_s = 1'b0;
        end
    end

    // Next-state logic; ring drop outranks cancel requests, which outrank phase changes
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ring) state_nx_s = ST_BEEP_ON;
                else      state_nx_s = ST_IDLE;
            end
            ST_BEEP_ON: begin
                if (!ring)             state_nx_s = ST_IDLE;
                else if (press_s)      state_nx_s = ST_CANCEL;
                else if (phase_done_s) state_nx_s = ST_BEEP_OFF;
                else                   state_nx_s = ST_BEEP_ON;
            end
            ST_BEEP_OFF: begin
                if (!ring)                                     state_nx_s = ST_IDLE;
                else if (press_s || (phase_done_s && timeout_hit_s)) state_nx_s = ST_CANCEL;
                else if (phase_done_s)                         state_nx_s = ST_BEEP_ON;
                else                                           state_nx_s = ST_BEEP_OFF;
            end
            ST_CANCEL: state_nx_s = ST_HOLD;
            ST_HOLD: begin
                if (!ring) state_nx_s = ST_IDLE;
                else       state_nx_s = ST_HOLD;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and phase counter, reloaded on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s != state_r || (state_r != ST_BEEP_ON && state_r != ST_BEEP_OFF)) begin
                phase_r <= '0;
            end else begin
                phase_r <= phase_r + 1'b1;
            end
        end
    end

    // Registered outputs decoded from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel  <= 1'b0;
            led     <= 1'b0;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
            tone_r  <= '0;
        end else begin
            cancel  <= (state_nx_s == ST_CANCEL);
            led     <= (state_nx_s == ST_BEEP_ON);
            ringing <= (state_nx_s == ST_BEEP_ON) || (state_nx_s == ST_BEEP_OFF);
            if (state_nx_s == ST_BEEP_ON && state_r == ST_BEEP_ON) begin
                if (tone_r == TN_LAST) begin
                    tone_r <= '0;
                    buzzer <= ~buzzer;
                end else begin
                    tone_r <= tone_r + 1'b1;
                    buzzer <= buzzer;
                end
            end else begin
                tone_r <= '0;
                buzzer <= 1'b0;
            end
        end
    end

endmodule
